pe_multimode: RTL
=================

Name: pe_multimode

Overview:
- Parametrised processing element, successor to the fixed 8-bit PE in the convolution array.
- Supports weight-stationary (WS) and output-stationary (OS) dataflow, selected per run.
- Signed MAC with configurable data and accumulator widths.
- Registered systolic forwarding of filter and ifmap.
- Selectable saturating or wrapping accumulation, with a sticky overflow flag.
- Instantiated in a 2-D PE grid; neighbours connect through the forwarding ports.

Parameters:
- DATA_W, 8: signed width of filter and ifmap operands.
- ACC_W, 20: signed width of psum and accumulator. Must satisfy ACC_W >= 2*DATA_W; elaboration error otherwise.
- SATURATE, 1: 1 = clamp to the ACC_W signed range; 0 = two's-complement wrap.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous, active-high reset.
- start_i  in  1  one-cycle pulse that begins a run; ignored unless the state is IDLE.
- mode_i  in  1  sampled with start_i; 0 = WS, 1 = OS.
- end_i  in  1  terminates the current run.
- filter_i  in  DATA_W  signed filter value.
- filter_valid_i  in  1  filter_i is valid.
- ifmap_i  in  DATA_W  signed ifmap value.
- ifmap_valid_i  in  1  ifmap_i is valid.
- psum_i  in  ACC_W  incoming partial sum (WS only).
- psum_valid_i  in  1  psum_i is valid.
- filter_o  out  DATA_W  registered copy of filter_i.
- filter_valid_o  out  1  registered copy of filter_valid_i.
- ifmap_o  out  DATA_W  registered copy of ifmap_i.
- ifmap_valid_o  out  1  registered copy of ifmap_valid_i.
- psum_o  out  ACC_W  result partial sum.
- psum_valid_o  out  1  one-cycle strobe; psum_o is valid.
- busy_o  out  1  high whenever the state is not IDLE.
- ovf_o  out  1  sticky overflow flag; cleared by an accepted start_i.

Behaviour:
- Reset: all outputs 0, weight register 0, accumulator 0, state IDLE. The clear is immediate and asynchronous, including mid-run.
- Forwarding: filter_o/filter_valid_o and ifmap_o/ifmap_valid_o are flopped copies of their inputs, 1-cycle latency. Forwarding runs in every state, independent of the FSM. Data registers hold their value when the matching valid is low.
- States: IDLE, WS_LOAD, WS_RUN, OS_RUN, OS_DRAIN.
- IDLE:
  - start_i with mode_i=0 -> WS_LOAD.
  - start_i with mode_i=1 -> OS_RUN, accumulator cleared.
  - An accepted start_i clears ovf_o.
- WS_LOAD: the first cycle with filter_valid_i captures filter_i into the weight register -> WS_RUN. end_i here -> IDLE.
- WS_RUN:
  - Each cycle with ifmap_valid_i: psum_o <= weight*ifmap_i + (psum_valid_i ? psum_i : 0).
  - psum_valid_o pulses 1 cycle later, at full throughput of one result per cycle.
  - filter_valid_i is ignored for the weight.
  - end_i -> IDLE; a MAC valid in the same cycle still completes.
- OS_RUN:
  - Each cycle with filter_valid_i && ifmap_valid_i: acc <= acc + filter_i*ifmap_i.
  - psum_i and psum_valid_i are ignored.
  - end_i -> OS_DRAIN; a MAC valid in the same cycle is included.
- OS_DRAIN (1 cycle): psum_o <= acc, psum_valid_o pulses on the next cycle, acc cleared, -> IDLE.
- OS latency: psum_valid_o is high exactly 2 cycles after end_i is sampled.
- Arithmetic:
  - Product is 2*DATA_W signed, sign-extended to ACC_W+1 bits before the add.
  - SATURATE=1: clamp to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
  - SATURATE=0: truncate to ACC_W bits.
  - ovf_o is set on any overflow in either mode.
- Simultaneous events:
  - start_i while busy is ignored.
  - end_i in IDLE is ignored.
  - end_i and start_i together in IDLE: start_i wins and end_i is dropped.
- psum_o holds its last value when psum_valid_o is low.

Decomposition:
- Package pe_pkg holds:
  - pe_mode_e (PE_WS, PE_OS).
  - pe_state_e (the five states).
  - Function sat_add(a, b, saturate) returning the sum and an overflow bit.
- Sub-module pe_mac: combinational signed multiply plus saturating add, shared by both modes; ports a, b, addend, sum, ovf.
- Top-level module holds the FSM, weight register, accumulator and forwarding registers.

Test Plan (DATA_W=8, ACC_W=20, SATURATE=1 unless noted):
- Assert rst_i, release mid-stream -> every output 0, busy_o=0; a following WS run produces a correct result.
- Forwarding: filter_i=0x5A with valid in IDLE -> filter_o=0x5A, filter_valid_o=1 the next cycle. Same check for ifmap during WS_RUN.
- WS: start mode=0, filter=3 valid, then ifmap=5 with psum=10 valid -> psum_o=25, psum_valid_o=1 one cycle later.
- WS continued: ifmap=-2 with no psum_valid -> psum_o=-6.
- OS: start mode=1, pairs (2,3), (-4,5), (7,7) with end_i on the last pair -> psum_o=35, psum_valid_o=1 two cycles after end_i, then busy_o=0.
- Saturation, WS with weight=127:
  - ifmap=127, psum=524287 -> psum_o=524287, ovf_o=1.
  - ifmap=-128, psum=-524288 -> psum_o=-524288.
  - The next start_i clears ovf_o.
- Wrap (SATURATE=0): weight=127, ifmap=127, psum=524287 -> psum_o=-508160, ovf_o=1.
- Reset mid-OS_RUN with acc=100: rst_i pulse -> outputs 0 immediately. A new OS run with a single pair (1,1) then end_i -> psum_o=1.

Source files
------------

// File: rtl/pe_multimode_pkg.sv
// Shared types and the saturating adder for the multi-mode processing element.
// sat_add works on left-justified operands so a single 64-bit adder serves any accumulator width.
package pe_pkg;

  typedef enum logic {
    PE_WS = 1'b0,
    PE_OS = 1'b1
  } pe_mode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WS_LOAD,
    ST_WS_RUN,
    ST_OS_RUN,
    ST_OS_DRAIN
  } pe_state_e;

  localparam int unsigned SUM_W = 64;

  typedef struct packed {
    logic [SUM_W-1:0] sum;
    logic             ovf;
  } sat_res_t;

  // Operands arrive shifted so their sign bit sits in bit SUM_W-1; overflow is then
  // the classic same-sign-in, different-sign-out rule, and the clamp values are the
  // full-width extremes whose top bits are the narrow extremes.
  function automatic sat_res_t sat_add(input logic signed [SUM_W-1:0] a,
                                       input logic signed [SUM_W-1:0] b,
                                       input logic                    saturate);
    sat_res_t                r;
    logic signed [SUM_W-1:0] s;
    s     = a + b;
    r.ovf = (a[SUM_W-1] == b[SUM_W-1]) && (s[SUM_W-1] != a[SUM_W-1]);
    r.sum = s;
    if (saturate && r.ovf) begin
      r.sum = a[SUM_W-1] ? {1'b1, {(SUM_W-1){1'b0}}} : {1'b0, {(SUM_W-1){1'b1}}};
    end
    return r;
  endfunction

endpackage

// File: rtl/pe_multimode_mac.sv
// Combinational signed multiply-accumulate shared by both dataflows; no state, no
// latency, no flow control. Result clamps or wraps to ACC_W bits and flags overflow.
module pe_mac import pe_pkg::*; #(
  parameter int DATA_W   = 8,
  parameter int ACC_W    = 20,
  parameter bit SATURATE = 1'b1
) (
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  input  logic signed [ACC_W-1:0]  addend,
  output logic signed [ACC_W-1:0]  sum,
  output logic                     ovf
);

  localparam int PROD_W = 2 * DATA_W;
  localparam int SHIFT  = int'(SUM_W) - ACC_W;

  logic signed [PROD_W-1:0] prod;
  logic signed [SUM_W-1:0]  prod_ext;
  logic signed [SUM_W-1:0]  addend_ext;
  sat_res_t                 res;
  logic                     unused_lo;

  assign prod = PROD_W'(a) * PROD_W'(b);

  // Left-justify both operands so the ACC_W range fills the adder's full range.
  assign prod_ext   = SUM_W'(prod) <<< SHIFT;
  assign addend_ext = SUM_W'(addend) <<< SHIFT;

  always_comb begin
    res = sat_add(addend_ext, prod_ext, SATURATE);
  end

  assign sum       = res.sum[SUM_W-1 -: ACC_W];
  assign ovf       = res.ovf;
  assign unused_lo = ^res.sum;

endmodule

// File: rtl/pe_multimode.sv
// Weight- or output-stationary systolic PE: forwarding 1 cycle, WS result 1 cycle, OS
// result 2 cycles after end_i. No backpressure; one MAC per cycle whenever valids are high.
module pe_multimode import pe_pkg::*; #(
  parameter int DATA_W   = 8,
  parameter int ACC_W    = 20,
  parameter bit SATURATE = 1'b1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic                     mode_i,
  input  logic                     end_i,
  input  logic signed [DATA_W-1:0] filter_i,
  input  logic                     filter_valid_i,
  input  logic signed [DATA_W-1:0] ifmap_i,
  input  logic                     ifmap_valid_i,
  input  logic signed [ACC_W-1:0]  psum_i,
  input  logic                     psum_valid_i,
  output logic signed [DATA_W-1:0] filter_o,
  output logic                     filter_valid_o,
  output logic signed [DATA_W-1:0] ifmap_o,
  output logic                     ifmap_valid_o,
  output logic signed [ACC_W-1:0]  psum_o,
  output logic                     psum_valid_o,
  output logic                     busy_o,
  output logic                     ovf_o
);

  if (ACC_W < 2 * DATA_W || ACC_W > int'(SUM_W)) begin : g_bad_width
    $error("pe_multimode: ACC_W must lie between 2*DATA_W and 64");
  end

  pe_state_e                state_q, state_d;
  logic signed [DATA_W-1:0] weight_q;
  logic signed [ACC_W-1:0]  acc_q;

  logic signed [DATA_W-1:0] mac_a;
  logic signed [ACC_W-1:0]  mac_addend;
  logic signed [ACC_W-1:0]  mac_sum;
  logic                     mac_ovf;
  logic                     start_ok, ws_mac, os_mac;

  assign start_ok = (state_q == ST_IDLE) && start_i;
  assign ws_mac   = (state_q == ST_WS_RUN) && ifmap_valid_i;
  assign os_mac   = (state_q == ST_OS_RUN) && filter_valid_i && ifmap_valid_i;
  assign busy_o   = (state_q != ST_IDLE);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        // start_i takes priority; a simultaneous end_i is simply not looked at here.
        if (start_i) state_d = (pe_mode_e'(mode_i) == PE_OS) ? ST_OS_RUN : ST_WS_LOAD;
      end
      ST_WS_LOAD: begin
        if (end_i)               state_d = ST_IDLE;
        else if (filter_valid_i) state_d = ST_WS_RUN;
      end
      ST_WS_RUN:   if (end_i) state_d = ST_IDLE;
      ST_OS_RUN:   if (end_i) state_d = ST_OS_DRAIN;
      ST_OS_DRAIN: state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // One multiplier: WS multiplies the held weight and adds the upstream psum,
  // OS multiplies the streaming pair and adds the local accumulator.
  always_comb begin
    mac_a      = filter_i;
    mac_addend = acc_q;
    if (state_q == ST_WS_RUN) begin
      mac_a      = weight_q;
      mac_addend = psum_valid_i ? psum_i : '0;
    end
  end

  pe_mac #(
    .DATA_W  (DATA_W),
    .ACC_W   (ACC_W),
    .SATURATE(SATURATE)
  ) u_mac (
    .a     (mac_a),
    .b     (ifmap_i),
    .addend(mac_addend),
    .sum   (mac_sum),
    .ovf   (mac_ovf)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      filter_o       <= '0;
      filter_valid_o <= 1'b0;
      ifmap_o        <= '0;
      ifmap_valid_o  <= 1'b0;
    end else begin
      filter_valid_o <= filter_valid_i;
      ifmap_valid_o  <= ifmap_valid_i;
      if (filter_valid_i) filter_o <= filter_i;
      if (ifmap_valid_i)  ifmap_o  <= ifmap_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      weight_q     <= '0;
      acc_q        <= '0;
      psum_o       <= '0;
      psum_valid_o <= 1'b0;
      ovf_o        <= 1'b0;
    end else begin
      state_q      <= state_d;
      psum_valid_o <= 1'b0;
      if (start_ok) begin
        ovf_o <= 1'b0;
        if (pe_mode_e'(mode_i) == PE_OS) acc_q <= '0;
      end
      if (state_q == ST_WS_LOAD && filter_valid_i) weight_q <= filter_i;
      if (ws_mac) begin
        psum_o       <= mac_sum;
        psum_valid_o <= 1'b1;
      end
      if (os_mac) acc_q <= mac_sum;
      if ((ws_mac || os_mac) && mac_ovf) ovf_o <= 1'b1;
      if (state_q == ST_OS_DRAIN) begin
        psum_o       <= acc_q;
        psum_valid_o <= 1'b1;
        acc_q        <= '0;
      end
    end
  end

endmodule
